// File: rtl/bubblesort_host_seq.sv
`default_nettype none
// ============================================================================
// bubblesort_host_seq : bus-master sequencer that loads, kicks, polls and
//                       unloads a scan-chain bubble sorter.   Rev 1.0
// ============================================================================
module bubblesort_host_seq #(
  parameter int                 N           = 8,
  parameter int                 WIDTH       = 8,
  parameter int                 IDWIDTH     = 8,
  parameter int                 CWIDTH      = 8,
  parameter int                 AW          = 16,
  parameter int                 DW          = 32,
  parameter logic [IDWIDTH-1:0] SCAN_ID     = 8'hFE,
  parameter logic [IDWIDTH-1:0] CTRL_ID     = 8'hFF,
  parameter int                 SORT_CYCLES = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  output logic             rs_valid,
  input  logic             rs_ready,
  output logic [WIDTH-1:0] rs_data,
  output logic             RD,
  output logic             WR,
  output logic [AW-1:0]    Addr,
  output logic [DW-1:0]    DataOut,
  input  logic [DW-1:0]    DataIn
);

  localparam int                  c_CNT_W     = $clog2(N + 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]  c_LOAD_LAST = c_CNT_W'(N - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ALL   = c_CNT_W'(N);
  localparam logic [AW-1:0]       c_SCAN_ADDR = AW'(SCAN_ID);
  localparam logic [AW-1:0]       c_CTRL_ADDR = AW'(CTRL_ID);
  localparam logic [DW-1:0]       c_KICK_DATA = DW'(SORT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_KICK = 3'd2,
    S_POLL = 3'd3,
    S_URD  = 3'd4,
    S_UGAP = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ld_ready;
  logic                r_rs_valid;
  logic [WIDTH-1:0]    r_rs_data;
  logic                r_rd;
  logic                r_wr;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_dout;

  // Upper DataIn bits are never consumed by this master.
  logic                w_unused_din;
  assign w_unused_din = &{1'b0, DataIn};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ld_ready <= 1'b0;
      r_rs_valid <= 1'b0;
      r_rs_data  <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_dout     <= '0;
    end else begin
      // Bus is idle (all zero) unless the current state drives a cycle.
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_dout <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_cnt      <= '0;
            r_ld_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_valid && r_ld_ready) begin
            r_wr   <= 1'b1;
            r_addr <= c_SCAN_ADDR;
            r_dout <= DW'(ld_data);
            r_cnt  <= r_cnt + c_CNT_ONE;
            if (r_cnt == c_LOAD_LAST) begin
              r_ld_ready <= 1'b0;
              r_state    <= S_KICK;
            end
          end
        end
        S_KICK: begin
          r_wr    <= 1'b1;
          r_addr  <= c_CTRL_ADDR;
          r_dout  <= c_KICK_DATA;
          r_state <= S_POLL;
        end
        S_POLL: begin
          // The first POLL cycle carries the kick write, so only judge
          // DataIn once a control read is actually on the bus.
          r_rd <= 1'b1;
          if (r_rd && (DataIn[CWIDTH-1:0] == '0)) begin
            r_addr  <= c_SCAN_ADDR;
            r_cnt   <= '0;
            r_state <= S_URD;
          end else begin
            r_addr <= c_CTRL_ADDR;
          end
        end
        S_URD: begin
          r_rs_data  <= DataIn[WIDTH-1:0];
          r_rs_valid <= 1'b1;
          r_state    <= S_UGAP;
        end
        S_UGAP: begin
          if (r_rs_valid) begin
            if (rs_ready) begin
              r_rs_valid <= 1'b0;
              r_cnt      <= r_cnt + c_CNT_ONE;
            end
          end else if (r_cnt == c_CNT_ALL) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_rd    <= 1'b1;
            r_addr  <= c_SCAN_ADDR;
            r_state <= S_URD;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ld_ready = r_ld_ready;
  assign rs_valid = r_rs_valid;
  assign rs_data  = r_rs_data;
  assign RD       = r_rd;
  assign WR       = r_wr;
  assign Addr     = r_addr;
  assign DataOut  = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_bubblesort_host_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_bubblesort_host_seq : scoreboard bench with a behavioural sorter slave.
//                          Rev 1.0
// ============================================================================
module tb_bubblesort_host_seq;
  localparam int          N      = 8;
  localparam int          SORTC  = 8;
  localparam logic [15:0] SCAN16 = 16'h00FE;
  localparam logic [15:0] CTRL16 = 16'h00FF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        rs_ready = 1'b0;
  logic        busy, done, ld_ready, rs_valid, RD, WR;
  logic [7:0]  rs_data;
  logic [15:0] Addr;
  logic [31:0] DataOut;
  logic [31:0] DataIn;

  int n_vec = 0;
  int n_miss = 0;

  logic [7:0] exp_q[$];
  logic [7:0] wr_log[$];
  int         rs_mode = 0;
  int         stall_cnt = 0;
  int         job_results = 0;
  int         ctrl_wr = 0;
  int         polls = 0;

  bubblesort_host_seq dut (
    .Clk(Clk), .Reset(Reset), .start(start), .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data),
    .RD(RD), .WR(WR), .Addr(Addr), .DataOut(DataOut), .DataIn(DataIn)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_rs_valid"}, rs_valid, 0);
    check({tag, "_rs_data"}, rs_data, 0);
    check({tag, "_RD"}, RD, 0);
    check({tag, "_WR"}, WR, 0);
    check({tag, "_Addr"}, Addr, 0);
    check({tag, "_DataOut"}, DataOut, 0);
  endtask

  // Slave: scan chain shifts in at position 0, reads pop position N-1;
  // control counts down one per cycle and the chain is sorted when it hits 0.
  logic [7:0]  chain [N];
  logic [31:0] scount = 0;
  initial for (int i = 0; i < N; i++) chain[i] = 8'h00;

  always_comb begin
    DataIn = 32'h0;
    if (RD && Addr == SCAN16)      DataIn = {24'h0, chain[N-1]};
    else if (RD && Addr == CTRL16) DataIn = scount;
  end

  always @(posedge Clk) begin : slave
    logic [7:0] t [N];
    logic [7:0] x;
    bit sort_now;
    sort_now = 1'b0;
    if (WR && Addr == SCAN16) begin
      for (int i = N-1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= DataOut[7:0];
    end else if (RD && Addr == SCAN16) begin
      for (int i = N-1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= 8'h00;
    end
    if (WR && Addr == CTRL16) begin
      scount <= DataOut;
      if (DataOut == 0) sort_now = 1'b1;
    end else if (scount != 0) begin
      scount <= scount - 1;
      if (scount == 1) sort_now = 1'b1;
    end
    if (sort_now) begin
      t = chain;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N-1; b++)
          if (t[b] > t[b+1]) begin x = t[b]; t[b] = t[b+1]; t[b+1] = x; end
      chain <= t;
    end
  end

  // Reference: the N loaded values, largest first.
  task automatic push_expected(input logic [7:0] v [N]);
    logic [7:0] s[$];
    int p;
    s = {};
    for (int i = 0; i < N; i++) begin
      p = 0;
      while (p < s.size() && s[p] >= v[i]) p++;
      s.insert(p, v[i]);
    end
    foreach (s[i]) exp_q.push_back(s[i]);
  endtask

  // Result consumer and scoreboard.
  bit         hold = 1'b0;
  logic [7:0] hold_data = 8'h00;
  always @(negedge Clk) begin
    if (!Reset) begin
      rs_ready = 1'b0;
      hold = 1'b0;
    end else begin
      case (rs_mode)
        0: rs_ready = 1'b1;
        1: rs_ready = 1'($urandom_range(0, 1));
        default: begin
          if (rs_valid && job_results == 1 && stall_cnt < 5) begin
            rs_ready = 1'b0;
            stall_cnt++;
          end else rs_ready = 1'b1;
        end
      endcase
      if (hold) begin
        check("rs_hold_valid", rs_valid, 1);
        check("rs_hold_data", rs_data, hold_data);
      end
      if (rs_valid && rs_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL result_unexpected: got %0d, required none", rs_data);
        end else check("result", rs_data, exp_q.pop_front());
        job_results++;
      end
      hold = rs_valid && !rs_ready;
      hold_data = rs_data;
    end
  end

  // Bus protocol monitor.
  bit prev_poll = 1'b0;
  bit prev_zero = 1'b0;
  always @(negedge Clk) begin
    if (!Reset) begin
      prev_poll = 1'b0;
    end else begin
      check("rd_wr_exclusive", RD && WR, 0);
      if (!RD && !WR) begin
        check("idle_addr", Addr, 0);
        check("idle_dataout", DataOut, 0);
      end
      if (RD && Addr == SCAN16) check("urd_no_pending", rs_valid, 0);
      if (prev_poll) begin
        if (prev_zero) check("urd_after_zero_poll", RD && Addr == SCAN16, 1);
        else           check("poll_continues", RD && Addr == CTRL16, 1);
      end
      prev_poll = RD && Addr == CTRL16;
      prev_zero = (DataIn[7:0] == 8'h00);
      if (RD && Addr == CTRL16) polls++;
      if (WR && Addr == SCAN16) begin
        check("scan_wr_zero_ext", DataOut[31:8], 0);
        wr_log.push_back(DataOut[7:0]);
      end
      if (WR && Addr == CTRL16) begin
        ctrl_wr++;
        check("kick_data", DataOut, SORTC);
      end
    end
  end

  task automatic run_job(input logic [7:0] v [N], input int ldm, input int rsm,
                         input bit poke, input int rst_after);
    int i, cyc, k;
    bit vv;
    rs_mode = rsm; stall_cnt = 0; job_results = 0;
    wr_log.delete(); ctrl_wr = 0; polls = 0;
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ld_ready_in_load", ld_ready, 1);
    i = 0; cyc = 0;
    while (i < N && cyc < 500) begin
      if (rst_after != 0 && i == rst_after) break;
      vv = (ldm == 0) ? 1'b1 : (ldm == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      ld_valid = vv; ld_data = v[i];
      start = poke && (cyc == 3);
      if (vv && ld_ready) i++;
      cyc++;
      @(negedge Clk);
    end
    ld_valid = 1'b0; start = 1'b0;
    if (cyc >= 500) begin
      n_vec++; n_miss++;
      $display("FAIL load_timeout: got %0d beats, required %0d", i, N);
      return;
    end
    if (rst_after != 0) begin
      #2 Reset = 1'b0;
      #1 check_all_zero("midload_reset");
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check("no_restart_busy", busy, 0);
      check("no_restart_ld_ready", ld_ready, 0);
      check("no_restart_bus", RD || WR, 0);
      return;
    end
    check("ld_ready_drop", ld_ready, 0);
    push_expected(v);
    k = 0;
    while (!done && k < 2000) begin
      start = poke && (k == 15);
      @(negedge Clk);
      k++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("busy_during_done", busy, 1);
    @(negedge Clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("results_per_job", job_results, N);
    check("scoreboard_empty", exp_q.size(), 0);
    check("scan_wr_count", wr_log.size(), N);
    for (int j = 0; j < N && j < wr_log.size(); j++) check("scan_wr_data", wr_log[j], v[j]);
    check("ctrl_wr_count", ctrl_wr, 1);
    check("poll_count", polls, SORTC + 1);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] job [N];
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_busy", busy, 0);

    job = '{8'd3, 8'd7, 8'd1, 8'd0, 8'd255, 8'd9, 8'd4, 8'd2};
    run_job(job, 0, 0, 1'b0, 0);

    for (int i = 0; i < N; i++) job[i] = 8'($urandom_range(0, 255));
    run_job(job, 1, 2, 1'b0, 0);

    for (int i = 0; i < N; i++) job[i] = 8'($urandom_range(0, 255));
    run_job(job, 0, 0, 1'b0, 4);
    for (int i = 0; i < N; i++) job[i] = 8'($urandom_range(0, 255));
    run_job(job, 0, 0, 1'b0, 0);

    for (int i = 0; i < N; i++) job[i] = 8'($urandom_range(0, 255));
    run_job(job, 2, 1, 1'b1, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) job[i] = 8'($urandom_range(0, 255));
      run_job(job, 2, 1, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bubblesort_host_seq.md
BUBBLESORT_HOST_SEQ -- requirements
Module: bubblesort_host_seq

Interface
REQ-001 SHALL have parameter N, default 8, number of sort registers on the scan chain.
REQ-002 SHALL have parameter WIDTH, default 8, element width.
REQ-003 SHALL have parameters IDWIDTH, CWIDTH, AW, DW, defaults 8, 8, 16, 32: node ID, control count, bus address and bus data widths.
REQ-004 SHALL have parameters SCAN_ID, CTRL_ID, SORT_CYCLES, defaults 8'hFE, 8'hFF, 8: scan port ID, control node ID, enable count written to control.
REQ-005 SHALL have port Clk, input, 1, sole clock; all flops update on its rising edge.
REQ-006 SHALL have port Reset, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have ports start (in, 1), busy (out, 1), done (out, 1): job launch and status.
REQ-008 SHALL have ports ld_valid (in, 1), ld_ready (out, 1), ld_data (in, WIDTH): unsorted element stream.
REQ-009 SHALL have ports rs_valid (out, 1), rs_ready (in, 1), rs_data (out, WIDTH): result stream.
REQ-010 SHALL have bus-master outputs RD (1), WR (1), Addr (AW), DataOut (DW) and bus input DataIn (DW) carrying slave read data.

Function
REQ-011 SHALL implement states IDLE, LOAD, KICK, POLL, URD, UGAP, DONE.
REQ-012 IDLE: start=1 -> LOAD, element counter cleared; start in any other state ignored.
REQ-013 LOAD: ld_ready=1; each ld_valid&&ld_ready beat -> next cycle exactly one WR cycle, Addr=SCAN_ID zero-extended, DataOut=ld_data zero-extended.
REQ-014 LOAD: gaps in ld_valid leave RD=WR=0, scan chain holds; after N accepted beats ld_ready drops and state -> KICK.
REQ-015 KICK: one WR cycle, Addr=CTRL_ID, DataOut=SORT_CYCLES; then -> POLL.
REQ-016 POLL: RD=1, Addr=CTRL_ID each cycle; DataIn[CWIDTH-1:0]==0 sampled at cycle end -> URD; SORT_CYCLES=0 exits on first poll.
REQ-017 URD: one RD cycle, Addr=SCAN_ID, entered only when no result pending; DataIn[WIDTH-1:0] captured into rs_data at cycle end, rs_valid set; -> UGAP.
REQ-018 UGAP: RD=WR=0 for at least one cycle, needed because slave scan read data lags by one shift; -> URD when rs_valid==0, else wait.
REQ-019 rs_valid/rs_data SHALL hold until rs_ready; rs_valid clears the cycle after the handshake.
REQ-020 Unload order: first result is the element in chain position N-1, largest after a full sort, then descending; exactly N results.
REQ-021 After the Nth handshake -> DONE: done=1 for one cycle, then IDLE.
REQ-022 busy=1 in every state except IDLE.
REQ-023 Bus outputs SHALL be registered; RD and WR never both 1; Addr and DataOut are 0 whenever RD=WR=0.
REQ-024 Element counter SHALL be $clog2(N+1) bits and count accepted loads and delivered results without wrap.

Reset
REQ-025 Reset=0 at any time, including mid-LOAD or mid-unload, SHALL asynchronously force IDLE, counters 0, RD=WR=0, Addr=0, DataOut=0, ld_ready=0, rs_valid=0, rs_data=0, busy=0, done=0.
REQ-026 After Reset deasserts, the first job SHALL need a fresh start; the partially loaded chain is not cleared by this block.

Verification
REQ-027 Sort: N=8, load 3,7,1,0,255,9,4,2, rs_ready=1 -> results 255,9,7,4,3,2,1,0, then done pulse, busy=0.
REQ-028 Load backpressure: ld_valid toggles 1,0,1,0 -> exactly 8 WR cycles to SCAN_ID with no duplicates, then one WR to CTRL_ID with data 8.
REQ-029 Poll: slave count reads 8,7,...,1,0 -> first URD RD cycle immediately after the poll that returns 0.
REQ-030 Result backpressure: rs_ready=0 for 5 cycles on result 2 -> rs_data stable, no RD issued, no result lost.
REQ-031 Reset asserted after 4 load beats -> all outputs 0 within the same cycle; a new start then loads 8 fresh beats.
REQ-032 start pulsed while busy -> ignored; protocol trace identical to a run without the pulse.
